// File: rtl/muldiv_unit.sv
// RV32M multiply/divide execute unit: single-cycle multiply from latched operands,
// radix-2 restoring divide, one-cycle registered write-back pulse.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  output logic            o_stall,
  output logic            o_busy,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_rd_wren
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [XLEN-1:0] neg_xlen(input logic [XLEN-1:0] v);
    return ~v + 32'd1;
  endfunction

  state_t          state_r, state_next_s;
  logic [2:0]      funct3_r;
  logic [4:0]      rd_r;
  logic [XLEN-1:0] a_r, b_r, rem_r, result_r;
  logic [4:0]      cnt_r;
  logic            neg_q_r, neg_r_r;
  logic            busy_r, wren_r;
  logic [4:0]      rd_out_r;
  logic [XLEN-1:0] data_out_r;

  // Decode of the incoming instruction for divide setup and special cases.
  logic            signed_div_s, a_neg_s, b_neg_s, div_zero_s, div_ovf_s, special_s;
  logic [XLEN-1:0] a_abs_s, b_abs_s, special_result_s;

  always_comb begin
    signed_div_s = ~i_funct3[0];
    a_neg_s      = signed_div_s & i_rs1_data[XLEN-1];
    b_neg_s      = signed_div_s & i_rs2_data[XLEN-1];
    a_abs_s      = a_neg_s ? neg_xlen(i_rs1_data) : i_rs1_data;
    b_abs_s      = b_neg_s ? neg_xlen(i_rs2_data) : i_rs2_data;
    div_zero_s   = (i_rs2_data == 32'h0000_0000);
    div_ovf_s    = signed_div_s & (i_rs1_data == 32'h8000_0000) & (i_rs2_data == 32'hFFFF_FFFF);
    special_s    = div_zero_s | div_ovf_s;
    if (div_zero_s) begin
      special_result_s = i_funct3[1] ? i_rs1_data : 32'hFFFF_FFFF;
    end else begin
      special_result_s = i_funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

  // 33-bit extended multiply on the latched operands.
  logic signed [XLEN:0]     mul_a_s, mul_b_s;
  logic signed [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]          mul_result_s;

  always_comb begin
    mul_a_s      = {(funct3_r[1:0] != 2'b11) & a_r[XLEN-1], a_r};
    mul_b_s      = {~funct3_r[1] & b_r[XLEN-1], b_r};
    prod_s       = mul_a_s * mul_b_s;
    mul_result_s = (funct3_r[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  // One restoring-divide step; a_r shifts out dividend bits and collects quotient bits.
  logic [XLEN:0]   shifted_s, diff_s;
  logic            qbit_s;
  logic [XLEN-1:0] rem_next_s, quo_next_s, div_result_s;

  always_comb begin
    shifted_s  = {rem_r, a_r[XLEN-1]};
    diff_s     = shifted_s - {1'b0, b_r};
    qbit_s     = ~diff_s[XLEN];
    rem_next_s = qbit_s ? diff_s[XLEN-1:0] : shifted_s[XLEN-1:0];
    quo_next_s = {a_r[XLEN-2:0], qbit_s};
    if (funct3_r[1]) begin
      div_result_s = neg_r_r ? neg_xlen(rem_next_s) : rem_next_s;
    end else begin
      div_result_s = neg_q_r ? neg_xlen(quo_next_s) : quo_next_s;
    end
  end

  // Next-state and stall decode.
  always_comb begin
    state_next_s = state_r;
    o_stall      = 1'b0;
    case (state_r)
      S_IDLE: begin
        o_stall = i_start;
        if (!i_start) begin
          state_next_s = S_IDLE;
        end else if (!i_funct3[2]) begin
          state_next_s = S_MUL;
        end else if (special_s) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_DIV;
        end
      end
      S_MUL: begin
        o_stall      = 1'b1;
        state_next_s = S_DONE;
      end
      S_DIV: begin
        o_stall = 1'b1;
        if (cnt_r == 5'd31) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_DIV;
        end
      end
      S_DONE: begin
        o_stall      = 1'b0;
        state_next_s = S_IDLE;
      end
      default: begin
        o_stall      = 1'b0;
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State register and registered busy flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != S_IDLE);
    end
  end

  // Operand capture, divide iteration and result registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      funct3_r <= 3'd0;
      rd_r     <= 5'd0;
      a_r      <= 32'h0000_0000;
      b_r      <= 32'h0000_0000;
      rem_r    <= 32'h0000_0000;
      result_r <= 32'h0000_0000;
      cnt_r    <= 5'd0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (i_start) begin
            funct3_r <= i_funct3;
            rd_r     <= i_rd_addr;
            rem_r    <= 32'h0000_0000;
            cnt_r    <= 5'd0;
            neg_q_r  <= a_neg_s ^ b_neg_s;
            neg_r_r  <= a_neg_s;
            if (!i_funct3[2]) begin
              a_r <= i_rs1_data;
              b_r <= i_rs2_data;
            end else if (special_s) begin
              result_r <= special_result_s;
            end else begin
              a_r <= a_abs_s;
              b_r <= b_abs_s;
            end
          end
        end
        S_MUL: begin
          result_r <= mul_result_s;
        end
        S_DIV: begin
          rem_r <= rem_next_s;
          a_r   <= quo_next_s;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            result_r <= div_result_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Write-back port: loaded from DONE, held otherwise; wren is a single-cycle pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wren_r     <= 1'b0;
      rd_out_r   <= 5'd0;
      data_out_r <= 32'h0000_0000;
    end else if (state_r == S_DONE) begin
      wren_r     <= (rd_r != 5'd0);
      rd_out_r   <= rd_r;
      data_out_r <= result_r;
    end else begin
      wren_r <= 1'b0;
    end
  end

  assign o_busy    = busy_r;
  assign o_rd_wren = wren_r;
  assign o_rd_addr = rd_out_r;
  assign o_rd_data = data_out_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, stall length, results and reset abort.
module tb_muldiv_unit;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic [4:0]  i_rd_addr;
  logic        o_stall;
  logic        o_busy;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_rd_wren;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_funct3   (i_funct3),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_rd_addr  (i_rd_addr),
    .o_stall    (o_stall),
    .o_busy     (o_busy),
    .o_rd_addr  (o_rd_addr),
    .o_rd_data  (o_rd_data),
    .o_rd_wren  (o_rd_wren)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Called at a sample point (1 time unit after a rising edge) with the DUT idle.
  // Returns at the sample point after edge En, where the write pulse is expected.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int n,
                        input logic [31:0] exp_data);
    int stall_cnt;
    int early_wren;
    i_start    = 1'b1;
    i_funct3   = f3;
    i_rs1_data = a;
    i_rs2_data = b;
    i_rd_addr  = rd;
    #1;
    stall_cnt  = o_stall ? 1 : 0;
    early_wren = 0;
    for (int k = 0; k <= n; k++) begin
      @(posedge i_clk);
      #1;
      if (k < n) begin
        if (o_stall) stall_cnt++;
        if (o_rd_wren) early_wren++;
      end
      if (k == 0) begin
        check_eq({tag, "_busy"}, 32'(o_busy), 32'd1);
        i_start    = 1'b0;
        i_funct3   = 3'($urandom_range(0, 7));
        i_rs1_data = $urandom;
        i_rs2_data = $urandom;
        i_rd_addr  = 5'($urandom_range(0, 31));
      end
    end
    check_eq({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(n));
    check_eq({tag, "_early_wren"}, 32'(early_wren), 32'd0);
    check_eq({tag, "_wren"}, 32'(o_rd_wren), (rd != 5'd0) ? 32'd1 : 32'd0);
    check_eq({tag, "_busy_end"}, 32'(o_busy), 32'd0);
    if (rd != 5'd0) begin
      check_eq({tag, "_addr"}, 32'(o_rd_addr), 32'(rd));
      check_eq({tag, "_data"}, o_rd_data, exp_data);
    end
  endtask

  initial begin
    int wren_seen;
    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_funct3   = 3'd0;
    i_rs1_data = 32'd0;
    i_rs2_data = 32'd0;
    i_rd_addr  = 5'd0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    #1;
    check_eq("rst_busy",  32'(o_busy),    32'd0);
    check_eq("rst_stall", 32'(o_stall),   32'd0);
    check_eq("rst_wren",  32'(o_rd_wren), 32'd0);
    check_eq("rst_addr",  32'(o_rd_addr), 32'd0);
    check_eq("rst_data",  o_rd_data,      32'd0);
    @(posedge i_clk);
    #1;

    // Multiplies
    run_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  2, 32'hFFFF_FFEB);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  2, 32'h4000_0000);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  2, 32'hFFFF_FFFE);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  2, 32'hFFFF_FFFF);
    // Normal divides
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         5'd9,  33, 32'hFFFF_FFFD);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 33, 32'hFFFF_FFFF);
    run_op("div_pn", 3'd4, 32'd100,       32'hFFFF_FFF9, 5'd11, 33, 32'hFFFF_FFF2);
    run_op("rem_pn", 3'd6, 32'd100,       32'hFFFF_FFF9, 5'd12, 33, 32'd2);
    // Special cases
    run_op("divu_z", 3'd5, 32'd100,       32'd0,         5'd13, 1, 32'hFFFF_FFFF);
    run_op("remu_z", 3'd7, 32'd100,       32'd0,         5'd14, 1, 32'd100);
    run_op("div_z",  3'd4, 32'hFFFF_FFF0, 32'd0,         5'd15, 1, 32'hFFFF_FFFF);
    run_op("div_ov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1, 32'h8000_0000);
    run_op("rem_ov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 1, 32'd0);
    // rd=0 multiply, then back-to-back unsigned divides
    run_op("mul_x0", 3'd0, 32'd3,         32'd4,         5'd0,  2, 32'd12);
    run_op("divu",   3'd5, 32'd10,        32'd3,         5'd7,  33, 32'd3);
    run_op("remu",   3'd7, 32'd10,        32'd3,         5'd18, 33, 32'd1);
    @(posedge i_clk);
    #1;
    check_eq("pulse_width", 32'(o_rd_wren), 32'd0);

    // Reset in the middle of a divide aborts with no write-back
    i_start    = 1'b1;
    i_funct3   = 3'd5;
    i_rs1_data = 32'd1000;
    i_rs2_data = 32'd7;
    i_rd_addr  = 5'd3;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    check_eq("abort_busy_pre", 32'(o_busy), 32'd1);
    i_reset = 1'b1;
    #1;
    check_eq("abort_busy",  32'(o_busy),    32'd0);
    check_eq("abort_stall", 32'(o_stall),   32'd0);
    check_eq("abort_data",  o_rd_data,      32'd0);
    #2;
    i_reset   = 1'b0;
    wren_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge i_clk);
      #1;
      if (o_rd_wren) wren_seen++;
    end
    check_eq("abort_no_wren", 32'(wren_seen), 32'd0);
    check_eq("abort_idle",    32'(o_busy),    32'd0);

    // Unit still works after the abort
    run_op("post_rst", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 33, 32'hFFFF_FFFD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
